// File: rtl/tick_bcd_counter.sv
// Four-digit BCD up/down counter advanced by rising edges of an upstream divided clock.
// The divided clock is synchronised and edge-detected as data, never used as a clock.
module tick_bcd_counter #(
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter bit WRAP        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_clk_in,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        step_o,
    output logic        tc,
    output logic        err
);

    localparam logic [15:0] BCD_MAX = 16'h9999;
    localparam logic [15:0] BCD_MIN = 16'h0000;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [15:0]            inc_val;
    logic [15:0]            dec_val;
    logic                   load_ok;

    // Decimal increment: a 9 rolls to 0 and carries into the next digit.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        // NOTE: blocking assignments are correct here; this is combinational
        // scratch work inside a function, not clocked state.
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digits_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign inc_val = bcd_inc(bcd);
    assign dec_val = bcd_dec(bcd);
    assign load_ok = digits_valid(load_val);

    // Flops reset high so a div_clk_in already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], div_clk_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign step_o = sync[SYNC_STAGES-1] & ~prev;

    // Priority: reset, then load, then a counted step, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd <= BCD_MIN;
            tc  <= 1'b0;
            err <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                if (load_ok) bcd <= load_val;
                else         err <= 1'b1;
            end else if (step_o && en) begin
                if (up) begin
                    if (bcd == BCD_MAX) begin
                        tc <= 1'b1;
                        if (WRAP) bcd <= BCD_MIN;
                    end else begin
                        bcd <= inc_val;
                    end
                end else begin
                    if (bcd == BCD_MIN) begin
                        tc <= 1'b1;
                        if (WRAP) bcd <= BCD_MAX;
                    end else begin
                        bcd <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: a wrapping and a saturating instance share
// all inputs; expected values are hand-derived from the counter's decimal behaviour.
module tb_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_clk_in = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;

    logic [15:0] bcd_w, bcd_s;
    logic        step_w, step_s, tc_w, tc_s, err_w, err_s;

    int checks = 0;
    int errors = 0;
    int pulses;

    tick_bcd_counter #(.SYNC_STAGES(2), .WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .div_clk_in(div_clk_in), .en(en), .up(up),
        .load(load), .load_val(load_val),
        .bcd(bcd_w), .step_o(step_w), .tc(tc_w), .err(err_w)
    );

    tick_bcd_counter #(.SYNC_STAGES(2), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .div_clk_in(div_clk_in), .en(en), .up(up),
        .load(load), .load_val(load_val),
        .bcd(bcd_s), .step_o(step_s), .tc(tc_s), .err(err_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rise of div_clk_in: step_o appears after two edges and the count lands on the third.
    task automatic rise();
        div_clk_in = 1'b1;
        tick(3);
    endtask

    task automatic fall();
        div_clk_in = 1'b0;
        tick(3);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    initial begin
        // Reset state
        tick(2);
        check("rst_bcd", bcd_w, 16'h0000);
        check("rst_tc", {15'd0, tc_w}, 16'd0);
        check("rst_err", {15'd0, err_w}, 16'd0);
        check("rst_step", {15'd0, step_w}, 16'd0);
        rst = 1'b0;
        tick(3);
        check("idle_step", {15'd0, step_w}, 16'd0);

        // Square wave, period 8 clk, 12 rising edges counted up
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            div_clk_in = 1'b1;
            tick();
            check("sq_step_k", {15'd0, step_w}, 16'd0);
            tick();
            check("sq_step_k1", {15'd0, step_w}, 16'd1);
            check("sq_bcd_k1", bcd_w, to_bcd(i));
            tick();
            check("sq_step_k2", {15'd0, step_w}, 16'd0);
            check("sq_bcd_k2", bcd_w, to_bcd(i + 1));
            tick();
            div_clk_in = 1'b0;
            for (int j = 0; j < 4; j++) begin
                tick();
                check("sq_fall_step", {15'd0, step_w}, 16'd0);
            end
        end
        check("sq_final", bcd_w, 16'h0012);
        check("sq_final_sat", bcd_s, 16'h0012);

        // Up across 9999
        load = 1'b1;
        load_val = 16'h9998;
        tick();
        load = 1'b0;
        check("ld_9998", bcd_w, 16'h9998);
        check("ld_tc", {15'd0, tc_w}, 16'd0);
        rise();
        check("up_9999", bcd_w, 16'h9999);
        check("up_9999_tc", {15'd0, tc_w}, 16'd0);
        fall();
        rise();
        check("wrap_0000", bcd_w, 16'h0000);
        check("wrap_tc", {15'd0, tc_w}, 16'd1);
        check("sat_9999", bcd_s, 16'h9999);
        check("sat_tc", {15'd0, tc_s}, 16'd1);
        tick();
        check("wrap_tc_low", {15'd0, tc_w}, 16'd0);
        fall();

        // Down into 0000
        load = 1'b1;
        load_val = 16'h0001;
        tick();
        load = 1'b0;
        up = 1'b0;
        rise();
        check("dn1_sat", bcd_s, 16'h0000);
        check("dn1_sat_tc", {15'd0, tc_s}, 16'd0);
        check("dn1_wrap", bcd_w, 16'h0000);
        fall();
        check("dn_tc_low", {15'd0, tc_s}, 16'd0);
        rise();
        check("dn2_sat", bcd_s, 16'h0000);
        check("dn2_sat_tc", {15'd0, tc_s}, 16'd1);
        check("dn2_wrap", bcd_w, 16'h9999);
        check("dn2_wrap_tc", {15'd0, tc_w}, 16'd1);
        fall();
        check("dn_tc_low2", {15'd0, tc_s}, 16'd0);
        rise();
        check("dn3_sat", bcd_s, 16'h0000);
        check("dn3_sat_tc", {15'd0, tc_s}, 16'd1);
        check("dn3_wrap", bcd_w, 16'h9998);
        check("dn3_wrap_tc", {15'd0, tc_w}, 16'd0);
        fall();

        // Invalid load sets a sticky error and leaves the count alone
        up = 1'b1;
        load = 1'b1;
        load_val = 16'h12A4;
        tick();
        load = 1'b0;
        check("bad_ld_bcd", bcd_w, 16'h9998);
        check("bad_ld_bcd_sat", bcd_s, 16'h0000);
        check("bad_ld_err", {15'd0, err_w}, 16'd1);
        tick(3);
        check("err_held", {15'd0, err_w}, 16'd1);
        load = 1'b1;
        load_val = 16'h0199;
        tick();
        load = 1'b0;
        check("ld_0199", bcd_w, 16'h0199);
        rise();
        check("up_0200", bcd_w, 16'h0200);
        check("err_still", {15'd0, err_s}, 16'd1);
        fall();

        // Reset overrides a simultaneous load
        rst = 1'b1;
        load = 1'b1;
        load_val = 16'h5555;
        tick();
        load = 1'b0;
        check("rst_ovr_bcd", bcd_w, 16'h0000);
        check("rst_ovr_err", {15'd0, err_w}, 16'd0);

        // div_clk_in high through reset release gives no step
        div_clk_in = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hi_rel_step", {15'd0, step_w}, 16'd0);
        end
        check("hi_rel_bcd", bcd_w, 16'h0000);
        fall();
        rise();
        check("hi_rel_next", bcd_w, 16'h0001);
        fall();

        // Load wins over a step in the same cycle
        div_clk_in = 1'b1;
        tick(2);
        check("ld_step_pulse", {15'd0, step_w}, 16'd1);
        load = 1'b1;
        load_val = 16'h0042;
        tick();
        load = 1'b0;
        check("ld_wins", bcd_w, 16'h0042);
        fall();

        // Steps with en=0 are dropped but still pulse step_o
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            div_clk_in = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (step_w) pulses++;
            end
            div_clk_in = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (step_w) pulses++;
            end
        end
        check("en0_pulses", 16'(pulses), 16'd5);
        check("en0_bcd", bcd_w, 16'h0042);

        // Direction change takes effect on the next step
        en = 1'b1;
        up = 1'b0;
        rise();
        check("dir_down", bcd_w, 16'h0041);
        fall();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
